// File: rtl/kovacs_window_stats.sv
// Per-window statistics (count, sum, sum of squares) over the gated Kovacs sample stream.
// Totals for each window of at least MIN_LEN samples are presented with a one-cycle valid strobe.
module kovacs_window_stats #(
    parameter int ACC_W   = 48,
    parameter int CNT_W   = 32,
    parameter int MIN_LEN = 4,
    parameter int IDX_W   = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             enable_i,
    input  logic [13:0]      data_i,
    input  logic [13:0]      indicator_i,
    output logic [ACC_W-1:0] sum_o,
    output logic [ACC_W-1:0] sumsq_o,
    output logic [CNT_W-1:0] count_o,
    output logic [IDX_W-1:0] window_idx_o,
    output logic             valid_o,
    output logic             ovf_o
);
    localparam int SQ_W = ((ACC_W > 28) ? ACC_W : 28) + 1;

    typedef enum logic [1:0] {SYNC, WAIT, ACC, DUMP} state_t;
    state_t state_reg;

    logic [13:0]      data_q;
    logic [13:0]      indicator_q;
    logic             enable_q;
    logic             act_q;

    logic [ACC_W-1:0] sum_reg, sumsq_reg;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;

    logic             load;
    logic [ACC_W-1:0] sum_base, sumsq_base;
    logic [CNT_W-1:0] count_base;
    logic             ovf_base;
    logic signed [27:0] data_ext;
    logic [27:0]      square;
    logic [ACC_W:0]   sum_add;
    logic [SQ_W-1:0]  sumsq_add;
    logic             sum_ovf, sumsq_ovf;

    logic [ACC_W-1:0] sum_next, sumsq_next;
    logic [CNT_W-1:0] count_next;
    logic             ovf_next;

    assign act_q    = (indicator_q != '0);
    assign load     = (state_reg != ACC);
    assign data_ext = {{14{data_q[13]}}, data_q};
    assign square   = data_ext * data_ext;

    // A load (first sample of a window) accumulates onto zero instead of the running totals.
    always_comb begin
        sum_base   = load ? '0 : sum_reg;
        sumsq_base = load ? '0 : sumsq_reg;
        count_base = load ? '0 : count_reg;
        ovf_base   = load ? 1'b0 : ovf_reg;

        sum_add    = {sum_base[ACC_W-1], sum_base} + {{(ACC_W + 1 - 14){data_q[13]}}, data_q};
        sumsq_add  = SQ_W'(sumsq_base) + SQ_W'(square);
        sum_ovf    = sum_add[ACC_W] ^ sum_add[ACC_W-1];
        sumsq_ovf  = |sumsq_add[SQ_W-1:ACC_W];

        count_next = (count_base == '1) ? count_base : count_base + CNT_W'(1);

        if (ovf_base) begin
            // After overflow the totals freeze; only the sample count keeps running.
            sum_next   = sum_base;
            sumsq_next = sumsq_base;
            ovf_next   = 1'b1;
        end else begin
            if (sum_ovf)
                sum_next = sum_add[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
                sum_next = sum_add[ACC_W-1:0];
            sumsq_next = sumsq_ovf ? '1 : sumsq_add[ACC_W-1:0];
            ovf_next   = sum_ovf | sumsq_ovf | (count_next == '1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q       <= '0;
            indicator_q  <= '0;
            enable_q     <= 1'b0;
            state_reg    <= SYNC;
            sum_reg      <= '0;
            sumsq_reg    <= '0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            sum_o        <= '0;
            sumsq_o      <= '0;
            count_o      <= '0;
            window_idx_o <= '0;
            valid_o      <= 1'b0;
            ovf_o        <= 1'b0;
        end else begin
            data_q      <= data_i;
            indicator_q <= indicator_i;
            enable_q    <= enable_i;
            valid_o     <= 1'b0;

            if (!enable_q) begin
                state_reg <= SYNC;
                sum_reg   <= '0;
                sumsq_reg <= '0;
                count_reg <= '0;
                ovf_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    SYNC: begin
                        if (!act_q)
                            state_reg <= WAIT;
                    end
                    WAIT: begin
                        if (act_q) begin
                            state_reg <= ACC;
                            sum_reg   <= sum_next;
                            sumsq_reg <= sumsq_next;
                            count_reg <= count_next;
                            ovf_reg   <= ovf_next;
                        end
                    end
                    ACC: begin
                        if (act_q) begin
                            sum_reg   <= sum_next;
                            sumsq_reg <= sumsq_next;
                            count_reg <= count_next;
                            ovf_reg   <= ovf_next;
                        end else begin
                            state_reg <= DUMP;
                        end
                    end
                    DUMP: begin
                        if (count_reg >= CNT_W'(MIN_LEN)) begin
                            sum_o        <= sum_reg;
                            sumsq_o      <= sumsq_reg;
                            count_o      <= count_reg;
                            ovf_o        <= ovf_reg;
                            valid_o      <= 1'b1;
                            window_idx_o <= window_idx_o + IDX_W'(1);
                        end
                        // A window that restarts right away loads its first sample here.
                        if (act_q) begin
                            state_reg <= ACC;
                            sum_reg   <= sum_next;
                            sumsq_reg <= sumsq_next;
                            count_reg <= count_next;
                            ovf_reg   <= ovf_next;
                        end else begin
                            state_reg <= WAIT;
                            sum_reg   <= '0;
                            sumsq_reg <= '0;
                            count_reg <= '0;
                            ovf_reg   <= 1'b0;
                        end
                    end
                    default: state_reg <= SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_kovacs_window_stats.sv
// Bench for kovacs_window_stats: a wide-accumulator and a narrow (ACC_W=20) instance share the stimulus,
// and reported windows are scoreboarded against a per-window arithmetic model.
module tb_kovacs_window_stats;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [13:0] data = '0;
    logic [13:0] indicator = '0;

    logic [47:0] sum_a, sumsq_a;
    logic [31:0] count_a;
    logic [15:0] idx_a;
    logic        valid_a, ovf_a;
    logic [19:0] sum_b, sumsq_b;
    logic [31:0] count_b;
    logic [15:0] idx_b;
    logic        valid_b, ovf_b;

    kovacs_window_stats dut_a (
        .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .data_i(data), .indicator_i(indicator),
        .sum_o(sum_a), .sumsq_o(sumsq_a), .count_o(count_a), .window_idx_o(idx_a),
        .valid_o(valid_a), .ovf_o(ovf_a)
    );

    kovacs_window_stats #(.ACC_W(20)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .data_i(data), .indicator_i(indicator),
        .sum_o(sum_b), .sumsq_o(sumsq_b), .count_o(count_b), .window_idx_o(idx_b),
        .valid_o(valid_b), .ovf_o(ovf_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint sum;
        longint sumsq;
        longint count;
        longint idx;
        bit     ovf;
        int     cyc;
    } rep_t;

    rep_t got_a[$], got_b[$], exp_a[$], exp_b[$];
    rep_t last_a, last_b, mon_a, mon_b;
    int   win[$];
    int   idx_model = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (valid_a) begin
            mon_a.sum = longint'(sum_a); mon_a.sumsq = longint'(sumsq_a);
            mon_a.count = longint'(count_a); mon_a.idx = longint'(idx_a);
            mon_a.ovf = ovf_a; mon_a.cyc = cyc;
            got_a.push_back(mon_a);
        end
        if (valid_b) begin
            mon_b.sum = longint'(sum_b); mon_b.sumsq = longint'(sumsq_b);
            mon_b.count = longint'(count_b); mon_b.idx = longint'(idx_b);
            mon_b.ovf = ovf_b; mon_b.cyc = cyc;
            got_b.push_back(mon_b);
        end
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Window totals from plain arithmetic: add, clamp on overflow, freeze totals afterwards.
    function automatic rep_t model_window(input int w);
        rep_t   r;
        longint s = 0, sq = 0, c = 0;
        bit     ov = 1'b0;
        longint smax  = (64'sd1 <<< (w - 1)) - 1;
        longint smin  = -(smax + 1);
        longint sqmax = (64'sd1 <<< w) - 1;
        foreach (win[i]) begin
            c++;
            if (!ov) begin
                s  += longint'(win[i]);
                sq += longint'(win[i]) * longint'(win[i]);
                if (s > smax) begin s = smax; ov = 1'b1; end
                if (s < smin) begin s = smin; ov = 1'b1; end
                if (sq > sqmax) begin sq = sqmax; ov = 1'b1; end
            end
        end
        r.sum   = s & sqmax;
        r.sumsq = sq;
        r.count = c;
        r.ovf   = ov;
        r.idx   = 0;
        r.cyc   = 0;
        return r;
    endfunction

    task automatic send_window(input int n, input bit rnd, input int fixed, input int gap);
        int   end_cyc;
        rep_t ra, rb;
        win.delete();
        for (int i = 0; i < n; i++) begin
            data      = rnd ? 14'($urandom) : fixed[13:0];
            indicator = 14'($urandom_range(1, 16383));
            win.push_back(int'($signed(data)));
            tick(1);
        end
        indicator = '0;
        data      = 14'($urandom);
        end_cyc   = cyc;
        if (n >= 4) begin
            idx_model++;
            ra = model_window(48);
            rb = model_window(20);
            ra.idx = idx_model & 16'hFFFF; rb.idx = ra.idx;
            ra.cyc = end_cyc + 3;          rb.cyc = end_cyc + 3;
            exp_a.push_back(ra); exp_b.push_back(rb);
            last_a = ra; last_b = rb;
        end
        tick(gap);
    endtask

    task automatic compare_rep(input string tag, input rep_t g, input rep_t e);
        check({tag, "_sum"},     g.sum,     e.sum);
        check({tag, "_sumsq"},   g.sumsq,   e.sumsq);
        check({tag, "_count"},   g.count,   e.count);
        check({tag, "_idx"},     g.idx,     e.idx);
        check({tag, "_ovf"},     longint'(g.ovf), longint'(e.ovf));
        check({tag, "_latency"}, longint'(g.cyc), longint'(e.cyc));
    endtask

    task automatic check_reports(input string tag);
        tick(4);
        check({tag, "_npulse_a"}, got_a.size(), exp_a.size());
        check({tag, "_npulse_b"}, got_b.size(), exp_b.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
            compare_rep({tag, "_a"}, got_a[i], exp_a[i]);
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
            compare_rep({tag, "_b"}, got_b[i], exp_b[i]);
        // Outputs must hold the last reported window between strobes.
        check({tag, "_hold_sum_a"},   longint'(sum_a),   last_a.sum);
        check({tag, "_hold_sumsq_a"}, longint'(sumsq_a), last_a.sumsq);
        check({tag, "_hold_count_a"}, longint'(count_a), last_a.count);
        check({tag, "_hold_idx_a"},   longint'(idx_a),   last_a.idx);
        check({tag, "_hold_ovf_a"},   longint'(ovf_a),   longint'(last_a.ovf));
        check({tag, "_hold_sum_b"},   longint'(sum_b),   last_b.sum);
        check({tag, "_hold_sumsq_b"}, longint'(sumsq_b), last_b.sumsq);
        check({tag, "_hold_ovf_b"},   longint'(ovf_b),   longint'(last_b.ovf));
        check({tag, "_valid_low"},    longint'(valid_a | valid_b), 0);
        $display("window step %s: %0d reports checked", tag, exp_a.size());
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic reset_model();
        idx_model = 0;
        last_a = '{0, 0, 0, 0, 1'b0, 0};
        last_b = '{0, 0, 0, 0, 1'b0, 0};
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    initial begin
        reset_model();
        rstn = 1'b0;
        tick(3);
        check_reports("reset");

        rstn      = 1'b1;
        enable    = 1'b1;
        indicator = '0;
        tick(5);
        send_window(10, 1'b0, 100, 6);
        check_reports("normal");
        send_window(4, 1'b0, -8192, 6);
        check_reports("neg_extreme");
        send_window(3, 1'b0, 7, 6);
        check_reports("short");
        send_window(6, 1'b0, -5, 6);
        check_reports("after_short");

        send_window(5, 1'b1, 0, 1);
        send_window(7, 1'b1, 0, 6);
        check_reports("back_to_back");

        for (int k = 0; k < 12; k++)
            send_window($urandom_range(1, 12), 1'b1, 0, $urandom_range(1, 4));
        check_reports("random");

        send_window(100, 1'b0, 8191, 6);
        check_reports("overflow");

        // Enable drops on the third sample; re-enabling mid-window must not count the tail.
        indicator = 14'd100; data = 14'd1;
        tick(2);
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(4);
        indicator = '0;
        tick(6);
        check_reports("abort");

        indicator = 14'd200; data = 14'd3;
        tick(3);
        #2 rstn = 1'b0;
        #1;
        reset_model();
        check("async_rst_sum_a",   longint'(sum_a),   0);
        check("async_rst_sumsq_a", longint'(sumsq_a), 0);
        check("async_rst_count_a", longint'(count_a), 0);
        check("async_rst_idx_a",   longint'(idx_a),   0);
        check("async_rst_ovf_a",   longint'(ovf_a),   0);
        check("async_rst_idx_b",   longint'(idx_b),   0);
        indicator = 14'd8191; data = 14'd9;
        tick(2);

        rstn   = 1'b1;
        enable = 1'b1;
        tick(7);
        indicator = '0;
        tick(1);
        send_window(5, 1'b0, 2, 6);
        check_reports("mid_start");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
